// File: rtl/load_store_unit_if.sv
// load_store_unit_if
// Groups the core-side request/response handshake and the data-memory
// port of the load/store unit.
//   slave  : the load/store unit's view (takes requests, drives memory)
//   master : the environment's view (core + data memory)
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : request
//   resp_valid/resp_rdata/resp_err                           : response
//   mem_we/mem_addr/mem_din/mem_dout                         : data memory
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_din
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
// Bridges the core memory stage to a word-only data memory with a
// registered address and a write one cycle after the address is sampled.
// Loads do lane extraction with sign/zero extension; byte/half stores are
// done as read-modify-write.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : load_store_unit_if.slave (request, response and memory signals)
// Parameter:
//   ADDRW : byte-address bits forwarded to memory; upper mem_addr bits are 0
// Build option:
//   MISALIGN_TRAP_EN defined   -> misaligned half/word accesses return
//                                 resp_err=1 one cycle after accept
//   MISALIGN_TRAP_EN undefined -> offending low address bits are ignored,
//                                 resp_err is tied 0
//
// state       | meaning
// ------------+----------------------------------------------------
// S_IDLE      | ready for a request, memory follows req_* directly
// S_LD_WAIT   | load word on mem_dout, extract lane into resp_rdata
// S_ST_COMMIT | word store: memory writes this cycle
// S_RMW_READ  | old word on mem_dout, merge new lane into it
// S_RMW_WRITE | merged word written this cycle
module load_store_unit #(
    parameter int ADDRW = 8
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_WAIT,
        S_ST_COMMIT,
        S_RMW_READ,
        S_RMW_WRITE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDRW-1:0]   addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [2:0]         f3_q, f3_d;
    logic [31:0]        merge_q, merge_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               resp_valid_q, resp_valid_d;
`ifdef MISALIGN_TRAP_EN
    logic               resp_err_q, resp_err_d;
`endif

    logic               accept;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_result;
    logic [31:0]        merged;

    // funct3[1:0] carries the size; funct3[2] selects zero extension.
    // Codes 3, 6, 7 fall through to word.
    function automatic logic is_byte(input logic [2:0] f3);
        return f3[1:0] == 2'b00;
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return f3[1:0] == 2'b01;
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        if (is_byte(f3))
            return 1'b0;
        else if (is_half(f3))
            return a[0];
        else
            return a != 2'b00;
    endfunction
`endif

    function automatic logic [31:0] mem_address(input logic [ADDRW-1:0] a);
        return {{(32-ADDRW){1'b0}}, a};
    endfunction

    assign accept = bus.req_valid && (state_q == S_IDLE);

    // Lane extraction and store merge both work off the latched address.
    // Low bits below the access size are never consulted, which is what
    // gives the align-down behaviour when misalignment is not trapped.
    always_comb begin
        ld_byte = bus.mem_dout[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];
        if (is_byte(f3_q))
            ld_result = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
        else if (is_half(f3_q))
            ld_result = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
        else
            ld_result = bus.mem_dout;

        merged = bus.mem_dout;
        if (is_byte(f3_q))
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else if (addr_q[1])
            merged[31:16] = wdata_q[15:0];
        else
            merged[15:0] = wdata_q[15:0];
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        f3_d         = f3_q;
        merge_d      = merge_q;
        rdata_d      = rdata_q;
        resp_valid_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
        resp_err_d   = 1'b0;
`endif
        bus.req_ready = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = mem_address(addr_q);
        bus.mem_din   = wdata_q;

        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                // Memory registers the address at the accept edge, so it must
                // see the live request rather than the latched copy.
                bus.mem_addr  = mem_address(bus.req_addr[ADDRW-1:0]);
                bus.mem_din   = bus.req_wdata;
                if (accept) begin
                    addr_d  = bus.req_addr[ADDRW-1:0];
                    wdata_d = bus.req_wdata;
                    f3_d    = bus.req_funct3;
`ifdef MISALIGN_TRAP_EN
                    if (misaligned(bus.req_funct3, bus.req_addr[1:0])) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else
`endif
                    if (!bus.req_we)
                        state_d = S_LD_WAIT;
                    else if (is_byte(bus.req_funct3) || is_half(bus.req_funct3))
                        state_d = S_RMW_READ;
                    else
                        state_d = S_ST_COMMIT;
                end
            end
            S_LD_WAIT: begin
                rdata_d      = ld_result;
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            S_ST_COMMIT: begin
                bus.mem_we   = 1'b1;
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            S_RMW_READ: begin
                // Memory samples mem_din here and writes it in RMW_WRITE.
                bus.mem_din = merged;
                merge_d     = merged;
                state_d     = S_RMW_WRITE;
            end
            S_RMW_WRITE: begin
                bus.mem_we   = 1'b1;
                bus.mem_din  = merge_q;
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            f3_q         <= '0;
            merge_q      <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            f3_q         <= f3_d;
            merge_q      <= merge_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
`ifdef MISALIGN_TRAP_EN
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
`ifdef MISALIGN_TRAP_EN
    assign bus.resp_err   = resp_err_q;
`else
    assign bus.resp_err   = 1'b0;
`endif

endmodule
